// File: rtl/id_queue_pkg.sv
// Shared parameters and the slot-1 issue-eligibility rule for the
// decoded-instruction issue queue.
package id_queue_pkg;
  localparam int unsigned DATA_W_DEF    = 128;
  localparam int unsigned DEPTH_DEF     = 4;
  localparam int unsigned IN_PORTS_DEF  = 2;
  localparam int unsigned OUT_PORTS_DEF = 2;

  // Slot 1 may issue alongside slot 0 only when slot 0 issues, an entry
  // exists behind the head, and neither entry is control flow. This keeps
  // every branch/jump alone in slot 0.
  function automatic logic slot1_ok(input logic slot0_vld, input logic slot1_cand,
                                    input logic cf0, input logic cf1);
    return slot0_vld & slot1_cand & ~cf0 & ~cf1;
  endfunction
endpackage

// File: rtl/id_queue_storage.sv
// Register-array storage for the issue queue: each entry carries the opaque
// payload plus its control-flow flag. Contents are never reset.
module id_queue_storage
  import id_queue_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned IN_PORTS  = IN_PORTS_DEF,
  parameter int unsigned OUT_PORTS = OUT_PORTS_DEF,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                                clk_i,
  input  logic [IN_PORTS-1:0]                 we_i,
  input  logic [IN_PORTS-1:0][AW-1:0]         waddr_i,
  input  logic [IN_PORTS-1:0][DATA_W-1:0]     wdata_i,
  input  logic [IN_PORTS-1:0]                 wcf_i,
  input  logic [OUT_PORTS-1:0][AW-1:0]        raddr_i,
  output logic [OUT_PORTS-1:0][DATA_W-1:0]    rdata_o,
  output logic [OUT_PORTS-1:0]                rcf_o
);
  logic [DATA_W:0] mem_q [DEPTH];

  // Write ports target distinct consecutive addresses, so order is irrelevant.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < int'(IN_PORTS); k++) begin
      if (we_i[k]) mem_q[waddr_i[k]] <= {wcf_i[k], wdata_i[k]};
    end
  end

  for (genvar j = 0; j < int'(OUT_PORTS); j++) begin : g_rd
    assign rdata_o[j] = mem_q[raddr_i[j]][DATA_W-1:0];
    assign rcf_o[j]   = mem_q[raddr_i[j]][DATA_W];
  end
endmodule

// File: rtl/id_issue_queue.sv
// In-order decoded-instruction queue between decode and issue. Accepts up to
// IN_PORTS entries and offers up to OUT_PORTS per cycle; control-flow entries
// issue alone in slot 0. Supports flush (drop all) and halt (stop issue).
module id_issue_queue
  import id_queue_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned IN_PORTS  = IN_PORTS_DEF,
  parameter int unsigned OUT_PORTS = OUT_PORTS_DEF,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic                             halt_i,
  input  logic [IN_PORTS-1:0]              in_valid_i,
  input  logic [IN_PORTS-1:0][DATA_W-1:0]  in_data_i,
  input  logic [IN_PORTS-1:0]              in_ctrl_flow_i,
  output logic [IN_PORTS-1:0]              in_ready_o,
  output logic [OUT_PORTS-1:0]             out_valid_o,
  output logic [OUT_PORTS-1:0][DATA_W-1:0] out_data_o,
  output logic [OUT_PORTS-1:0]             out_ctrl_flow_o,
  input  logic [OUT_PORTS-1:0]             issue_ack_i,
  output logic [CW-1:0]                    occupancy_o
);
  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [IN_PORTS-1:0]          we;
  logic [IN_PORTS-1:0][AW-1:0]  waddr;
  logic [OUT_PORTS-1:0][AW-1:0] raddr;
  logic [OUT_PORTS-1:0]         cand;
  logic                         slot0_vld;
  int                           push_n, pop_n;

  // Free space is judged on the registered count only, so ready never
  // depends on same-cycle acks.
  for (genvar k = 0; k < int'(IN_PORTS); k++) begin : g_in
    assign in_ready_o[k] = ((int'(DEPTH) - int'(count_q)) > k) & ~rst_i & ~flush_i;
    assign we[k]         = in_valid_i[k] & in_ready_o[k];
    assign waddr[k]      = wptr_q + AW'(k);
  end

  for (genvar j = 0; j < int'(OUT_PORTS); j++) begin : g_out
    assign raddr[j] = rptr_q + AW'(j);
    assign cand[j]  = int'(count_q) > j;
  end

  id_queue_storage #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .IN_PORTS(IN_PORTS), .OUT_PORTS(OUT_PORTS)
  ) u_storage (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (in_data_i),
    .wcf_i   (in_ctrl_flow_i),
    .raddr_i (raddr),
    .rdata_o (out_data_o),
    .rcf_o   (out_ctrl_flow_o)
  );

  assign slot0_vld      = cand[0] & ~halt_i;
  assign out_valid_o[0] = slot0_vld;
  if (OUT_PORTS > 1) begin : g_slot1
    assign out_valid_o[1] = slot1_ok(slot0_vld, cand[1], out_ctrl_flow_o[0], out_ctrl_flow_o[1]);
  end

  assign occupancy_o = count_q;

  // Count accepted pushes and acked pops; acks are ignored while flushing.
  always_comb begin
    push_n = 0;
    pop_n  = 0;
    for (int k = 0; k < int'(IN_PORTS); k++) if (we[k]) push_n = push_n + 1;
    for (int j = 0; j < int'(OUT_PORTS); j++)
      if (issue_ack_i[j] & out_valid_o[j] & ~flush_i) pop_n = pop_n + 1;
  end

  // Next-state pointers and count; flush wins over any traffic.
  always_comb begin
    rptr_d  = rptr_q + AW'(pop_n);
    wptr_d  = wptr_q + AW'(push_n);
    count_d = CW'(int'(count_q) + push_n - pop_n);
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end
  end

  // Pointer/count registers; storage contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_id_issue_queue.sv
module tb_id_issue_queue;
  localparam int DW = 128;

  logic               clk = 1'b0;
  logic               rst_i, flush_i, halt_i;
  logic [1:0]         in_valid_i, in_ctrl_flow_i, in_ready_o;
  logic [1:0][DW-1:0] in_data_i;
  logic [1:0]         out_valid_o, out_ctrl_flow_o, issue_ack_i;
  logic [1:0][DW-1:0] out_data_o;
  logic [2:0]         occupancy_o;

  int tests = 0;
  int fails = 0;

  id_issue_queue dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .halt_i(halt_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ctrl_flow_i(in_ctrl_flow_i),
    .in_ready_o(in_ready_o), .out_valid_o(out_valid_o), .out_data_o(out_data_o),
    .out_ctrl_flow_o(out_ctrl_flow_o), .issue_ack_i(issue_ack_i), .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  // Ack protocol: prefix only, and only on offered slots.
  always @(posedge clk) begin
    if (!rst_i) begin
      assert (!(issue_ack_i[1] && !issue_ack_i[0])) else $error("non-prefix ack");
      assert ((issue_ack_i & ~out_valid_o) == 2'b00) else $error("ack on invalid slot");
    end
  end

  function automatic logic [DW-1:0] ent(input int i);
    return {96'hA5A5_0000_0000_0000_0000_5A5A, 32'(i)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush_i = 0; halt_i = 0; in_valid_i = 0; in_ctrl_flow_i = 0; issue_ack_i = 0;
    in_data_i = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1;
    tick();
    rst_i = 0;
  endtask

  task automatic push2(input int a, input int b);
    in_valid_i = 2'b11; in_data_i[0] = ent(a); in_data_i[1] = ent(b); in_ctrl_flow_i = 2'b00;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1;
    in_valid_i = 2'b11;
    #1;
    tests++; if (in_ready_o !== 2'b00) begin fails++; $display("FAIL reset_ready got=%b exp=00", in_ready_o); end
    tick();
    tests++; if (occupancy_o !== 3'd0) begin fails++; $display("FAIL reset_occ got=%0d exp=0", occupancy_o); end
    tests++; if (out_valid_o !== 2'b00) begin fails++; $display("FAIL reset_valid got=%b exp=00", out_valid_o); end
    rst_i = 0; in_valid_i = 0;
    #1;
    tests++; if (in_ready_o !== 2'b11) begin fails++; $display("FAIL post_reset_ready got=%b exp=11", in_ready_o); end
  endtask

  task automatic test_fill();
    do_reset();
    push2(0, 1);
    tick();
    tests++; if (occupancy_o !== 3'd2) begin fails++; $display("FAIL fill_occ2 got=%0d exp=2", occupancy_o); end
    push2(2, 3);
    tick();
    idle();
    #1;
    tests++; if (occupancy_o !== 3'd4) begin fails++; $display("FAIL fill_occ4 got=%0d exp=4", occupancy_o); end
    tests++; if (in_ready_o !== 2'b00) begin fails++; $display("FAIL fill_ready got=%b exp=00", in_ready_o); end
    tests++; if (out_valid_o !== 2'b11) begin fails++; $display("FAIL fill_valid got=%b exp=11", out_valid_o); end
    tests++; if (out_data_o[0] !== ent(0) || out_data_o[1] !== ent(1)) begin
      fails++; $display("FAIL fill_data got=%0h,%0h exp=%0h,%0h", out_data_o[0], out_data_o[1], ent(0), ent(1));
    end
  endtask

  task automatic test_dual_issue_wrap();
    int pushed = 0, issued = 0, cyc = 0;
    logic ok = 1'b1, occ_ok = 1'b1;
    do_reset();
    while (issued < 10 && cyc < 20) begin
      if (pushed < 10) push2(pushed, pushed + 1); else in_valid_i = 2'b00;
      #1;
      issue_ack_i = out_valid_o;
      if (occupancy_o > 3'd2) occ_ok = 1'b0;
      if (out_valid_o == 2'b11) begin
        if (out_data_o[0] !== ent(issued) || out_data_o[1] !== ent(issued + 1)) ok = 1'b0;
        issued += 2;
      end else if (out_valid_o != 2'b00) ok = 1'b0;
      if (pushed < 10) pushed += 2;
      tick();
      cyc++;
    end
    idle();
    tests++; if (!ok) begin fails++; $display("FAIL dual_order got=bad exp=in-order pairs"); end
    tests++; if (!occ_ok) begin fails++; $display("FAIL dual_occ got=>2 exp=<=2"); end
    tests++; if (issued != 10) begin fails++; $display("FAIL dual_count got=%0d exp=10", issued); end
    tests++; if (cyc != 6) begin fails++; $display("FAIL dual_cycles got=%0d exp=6", cyc); end
    tests++; if (occupancy_o !== 3'd0) begin fails++; $display("FAIL dual_drain got=%0d exp=0", occupancy_o); end
  endtask

  task automatic test_ctrl_flow_split();
    do_reset();
    push2(20, 21);
    in_ctrl_flow_i = 2'b10;
    tick();
    idle();
    #1;
    tests++; if (out_valid_o !== 2'b01) begin fails++; $display("FAIL cf_valid1 got=%b exp=01", out_valid_o); end
    tests++; if (out_data_o[0] !== ent(20)) begin fails++; $display("FAIL cf_head1 got=%0h exp=%0h", out_data_o[0], ent(20)); end
    issue_ack_i = 2'b01;
    tick();
    issue_ack_i = 2'b00;
    #1;
    tests++; if (out_valid_o !== 2'b01) begin fails++; $display("FAIL cf_valid2 got=%b exp=01", out_valid_o); end
    tests++; if (out_data_o[0] !== ent(21) || out_ctrl_flow_o[0] !== 1'b1) begin
      fails++; $display("FAIL cf_head2 got=%0h/%b exp=%0h/1", out_data_o[0], out_ctrl_flow_o[0], ent(21));
    end
    tests++; if (occupancy_o !== 3'd1) begin fails++; $display("FAIL cf_occ got=%0d exp=1", occupancy_o); end
  endtask

  task automatic test_full_traffic();
    do_reset();
    push2(30, 31); tick();
    push2(32, 33); tick();
    push2(34, 35);
    issue_ack_i = 2'b11;
    #1;
    tests++; if (in_ready_o !== 2'b00) begin fails++; $display("FAIL full_ready got=%b exp=00", in_ready_o); end
    tick();
    issue_ack_i = 2'b00;
    #1;
    tests++; if (occupancy_o !== 3'd2) begin fails++; $display("FAIL full_occ got=%0d exp=2", occupancy_o); end
    tests++; if (in_ready_o !== 2'b11) begin fails++; $display("FAIL full_ready2 got=%b exp=11", in_ready_o); end
    tick();
    in_valid_i = 2'b00;
    #1;
    tests++; if (occupancy_o !== 3'd4) begin fails++; $display("FAIL full_occ4 got=%0d exp=4", occupancy_o); end
    tests++; if (out_data_o[0] !== ent(32)) begin fails++; $display("FAIL full_head got=%0h exp=%0h", out_data_o[0], ent(32)); end
    issue_ack_i = 2'b11;
    tick();
    issue_ack_i = 2'b00;
    #1;
    tests++; if (out_data_o[0] !== ent(34) || out_data_o[1] !== ent(35)) begin
      fails++; $display("FAIL full_tail got=%0h,%0h exp=%0h,%0h", out_data_o[0], out_data_o[1], ent(34), ent(35));
    end
  endtask

  task automatic test_flush();
    do_reset();
    push2(40, 41); tick();
    in_valid_i = 2'b01; in_data_i[0] = ent(42); tick();
    flush_i = 1; push2(43, 44); issue_ack_i = 2'b01;
    #1;
    tests++; if (in_ready_o !== 2'b00) begin fails++; $display("FAIL flush_ready got=%b exp=00", in_ready_o); end
    tests++; if (out_valid_o !== 2'b11) begin fails++; $display("FAIL flush_valid_cyc got=%b exp=11", out_valid_o); end
    tick();
    idle();
    #1;
    tests++; if (occupancy_o !== 3'd0) begin fails++; $display("FAIL flush_occ got=%0d exp=0", occupancy_o); end
    tests++; if (out_valid_o !== 2'b00) begin fails++; $display("FAIL flush_valid got=%b exp=00", out_valid_o); end
    in_valid_i = 2'b01; in_data_i[0] = ent(45);
    tick();
    idle();
    #1;
    tests++; if (out_valid_o !== 2'b01 || out_data_o[0] !== ent(45)) begin
      fails++; $display("FAIL flush_after got=%b/%0h exp=01/%0h", out_valid_o, out_data_o[0], ent(45));
    end
  endtask

  task automatic test_halt();
    logic vbad = 1'b0;
    do_reset();
    halt_i = 1;
    for (int c = 0; c < 3; c++) begin
      push2(50 + 2 * c, 51 + 2 * c);
      #1;
      if (out_valid_o !== 2'b00) vbad = 1'b1;
      tick();
    end
    in_valid_i = 2'b00;
    #1;
    tests++; if (vbad || out_valid_o !== 2'b00) begin fails++; $display("FAIL halt_valid got=%b exp=00", out_valid_o); end
    tests++; if (occupancy_o !== 3'd4) begin fails++; $display("FAIL halt_occ got=%0d exp=4", occupancy_o); end
    halt_i = 0;
    #1;
    tests++; if (out_valid_o !== 2'b11 || out_data_o[0] !== ent(50)) begin
      fails++; $display("FAIL halt_release got=%b/%0h exp=11/%0h", out_valid_o, out_data_o[0], ent(50));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push2(60, 61); tick();
    push2(62, 63); flush_i = 0; halt_i = 1;
    rst_i = 1;
    tick();
    rst_i = 0; idle();
    #1;
    tests++; if (occupancy_o !== 3'd0 || out_valid_o !== 2'b00) begin
      fails++; $display("FAIL reset_mid got=%0d/%b exp=0/00", occupancy_o, out_valid_o);
    end
  endtask

  initial begin
    rst_i = 1;
    idle();
    tick();
    test_reset();
    test_fill();
    test_dual_issue_wrap();
    test_ctrl_flow_split();
    test_full_traffic();
    test_flush();
    test_halt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/id_issue_queue.md
# id_issue_queue

Parametrised, in-order decoded-instruction queue between the decoder and the issue stage. It generalises the single-entry fetch-to-issue handshake to IN_PORTS decoded instructions accepted and OUT_PORTS offered per cycle, with a DEPTH-entry circular buffer. It also enforces a one-control-flow-instruction-per-cycle issue rule and supports flush and halt. The payload is opaque (DATA_W bits), so the queue is independent of the decoder's scoreboard-entry layout.

## Interface
- DATA_W, 128: width of one decoded entry.
- DEPTH, 4: buffer entries; power of two, ≥ max(IN_PORTS, OUT_PORTS).
- IN_PORTS, 2: decoded entries accepted per cycle (1..2).
- OUT_PORTS, 2: entries offered to issue per cycle (1..2).
- clk_i  in  1  clock.
- rst_i  in  1  reset: one clock; reset is synchronous and active-high.
- flush_i  in  1  discard all buffered entries.
- halt_i  in  1  debug/halt request; suppresses issue, buffering continues.
- in_valid_i  in  IN_PORTS  entry k valid; must be a prefix (valid[1] implies valid[0]).
- in_data_i  in  IN_PORTS×DATA_W  decoded entries, port 0 oldest.
- in_ctrl_flow_i  in  IN_PORTS  entry is a branch/jump.
- in_ready_o  out  IN_PORTS  port k accepted this cycle when valid&ready.
- out_valid_o  out  OUT_PORTS  slot j holds issuable entry.
- out_data_o  out  OUT_PORTS×DATA_W  slot 0 = queue head.
- out_ctrl_flow_o  out  OUT_PORTS  slot entry is control flow.
- issue_ack_i  in  OUT_PORTS  issue consumed slot j; must be a prefix and only where out_valid_o set.
- occupancy_o  out  $clog2(DEPTH+1)  entries currently held.

## Operation
- State: storage array, read ptr, write ptr ($clog2(DEPTH) bits, natural wrap), count ($clog2(DEPTH+1) bits).
- Push: in_ready_o[k] = (DEPTH − count > k) & ~rst_i & ~flush_i. Free space is computed on the registered count; same-cycle pops do not free space. Accepted entries are written at wptr, wptr+1 in port order.
- Offer: slot j is a candidate if count > j. Slot 0 is valid if it is a candidate and ~halt_i. Slot 1 is valid only if slot 0 is valid, slot 1 is a candidate, and neither entry 0 nor entry 1 is control flow. A control-flow entry therefore always issues alone, in slot 0.
- Pop: number of pops = popcount(issue_ack_i & out_valid_o); rptr advances by that number. A non-prefix ack is a protocol error; the bench asserts on it.
- count_next = count + pushes − pops. Simultaneous push and pop at full is legal; space is still judged on the old count.
- Flush: takes priority over push and pop. rptr, wptr and count become 0 next cycle. Pushes in the flush cycle are dropped (in_ready_o is low). out_valid_o is not masked during the flush cycle, but acks in that cycle are ignored.
- Halt: out_valid_o is forced to 0 and the contents are frozen at the head; pushes continue until full.
- Storage contents are not reset; only pointers and count are reset.

## Timing
- Reset values: out_valid_o=0, in_ready_o=0 while rst_i is high, occupancy_o=0. After reset deasserts, in_ready_o is all-ones in the first cycle.
- Latency: an entry accepted at edge n is offered in out_valid_o from cycle n+1. There is no bypass.
- out_valid_o, out_data_o and out_ctrl_flow_o are combinational from registered state plus halt_i. in_ready_o depends only on count, rst_i and flush_i. There is no combinational path from ack to ready.
- Throughput: sustained min(IN_PORTS, OUT_PORTS) entries/cycle when no control flow is present and DEPTH ≥ 2×IN_PORTS.
- Reset mid-operation: the state clears on the next edge regardless of flush, halt, push or ack.

## Structure
- Package id_queue_pkg: the default parameters and a helper function for the slot-1 issue-eligibility rule. The function is shared with the issue stage's assertions.
- One natural sub-module: id_queue_storage (DEPTH×DATA_W register array, IN_PORTS write ports, OUT_PORTS read ports). Control logic stays in the top module.

## Test plan
- Reset then fill: DEPTH=4, push 2+2 non-control-flow entries with no ack → occupancy_o 2 then 4, in_ready_o=00 when full, slots show entries 0,1.
- Dual issue with wrap: stream 10 entries with full ack → 2 issued per cycle, pointers wrap twice, order preserved, occupancy_o ≤ 2.
- Control-flow split: head non-control-flow, entry 1 control flow → out_valid_o=01. After one ack, the control-flow entry is at the head and out_valid_o=01 again.
- Full with simultaneous traffic: count=4, push 2 and ack 2 in the same cycle → push rejected, occupancy_o=2 next cycle. The same push is accepted in the following cycle.
- Flush with traffic: count=3, flush_i asserted with push 2 and ack 1 → occupancy_o=0 and out_valid_o=00 next cycle. Data pushed afterwards appears at slot 0.
- Halt then release: halt_i high for 3 cycles while pushing → out_valid_o=00 and occupancy_o rises to 4. On release, the oldest entry is offered first.
